// File: rtl/pipo_arbiter.sv
// pipo_arbiter: round-robin arbiter sharing one DW-bit holding register between N_REQ requesters
// Ports: clk, reset (async, active-high); req[N_REQ] request levels; din[N_REQ*DW] packed data,
//        requester i at din[i*DW +: DW]; gnt one-hot registered grant; dout shared register;
//        dout_valid high for HOLD cycles per transfer; owner last granted index; busy = not idle.
module pipo_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW = 4,
  parameter int HOLD = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       dout,
  output logic                dout_valid,
  output logic [IW-1:0]       owner,
  output logic                busy
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_HOLD = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] rr_ptr, win, nxt_ptr;
  logic [IW:0] idx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] sel;
  // descending scan so the requester nearest rr_ptr overwrites the others
  always_comb begin
    win = rr_ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      idx = (idx >= (IW+1)'(N_REQ)) ? idx - (IW+1)'(N_REQ) : idx;
      if (req[idx[IW-1:0]]) win = idx[IW-1:0];
    end
  end
  always_comb begin
    sel = '0;
    for (int k = 0; k < N_REQ; k++)
      if (owner == IW'(k)) sel = din[k*DW +: DW];
  end
  assign nxt_ptr = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      gnt <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      owner <= '0;
      rr_ptr <= '0;
      cnt <= '0;
    end else if (state == S_IDLE) begin
      if (|req) begin
        gnt <= N_REQ'(1) << win;
        owner <= win;
        state <= S_LOAD;
      end
    end else if (state == S_LOAD) begin
      dout <= sel;
      dout_valid <= 1'b1;
      gnt <= '0;
      rr_ptr <= nxt_ptr;
      cnt <= CW'(HOLD - 1);
      state <= S_HOLD;
    end else if (cnt == '0) begin
      dout_valid <= 1'b0;
      state <= S_IDLE;
    end else begin
      cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_pipo_arbiter.sv
// tb_pipo_arbiter: directed and randomized checks of pipo_arbiter against a transaction-level model
module tb_pipo_arbiter;
  localparam int N = 4, DW = 4, HOLD = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*DW-1:0] din = '0;
  logic [N-1:0] gnt;
  logic [DW-1:0] dout;
  logic dout_valid, busy;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pipo_arbiter #(.N_REQ(N), .DW(DW), .HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt),
    .dout(dout), .dout_valid(dout_valid), .owner(owner), .busy(busy)
  );
  // model: m_t counts cycles left in the transfer (HOLD+1 = grant cycle, 0 = idle)
  int m_t, m_ptr, m_w;
  logic [N-1:0] m_gnt;
  logic [DW-1:0] m_dout;
  logic m_valid;
  logic [1:0] m_owner;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0; m_ptr = 0; m_w = 0; m_gnt = '0; m_dout = '0; m_valid = 0; m_owner = '0;
    end else if (m_t == 0) begin
      if (req != 0) begin
        m_w = -1;
        for (int k = 0; k < N; k++)
          if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
        m_gnt = N'(1 << m_w);
        m_owner = 2'(m_w);
        m_t = HOLD + 1;
      end
    end else if (m_t == HOLD + 1) begin
      m_dout = din[m_w*DW +: DW];
      m_valid = 1;
      m_gnt = '0;
      m_ptr = (m_w + 1) % N;
      m_t--;
    end else begin
      m_t--;
      if (m_t == 0) m_valid = 0;
    end
  end
  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1; req = '0;
    @(negedge clk); reset = 1'b0;
  endtask
  task automatic wait_gnt();
    int n = 0;
    while (gnt == '0 && n < 30) begin @(negedge clk); n++; end
    if (gnt == '0) begin
      checks++; failures++;
      $display("FAIL wait_gnt timeout: gnt=%b required nonzero", gnt);
    end
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({gnt, dout, dout_valid, owner, busy} !== '0) begin
      failures++;
      $display("FAIL reset_initial: got gnt=%b dout=%h v=%b owner=%0d busy=%b, required all 0", gnt, dout, dout_valid, owner, busy);
    end
    @(negedge clk); reset = 1'b0; din = 16'hF00F; req = 4'b0001;
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt, dout, dout_valid, owner, busy} !== '0) begin
      failures++;
      $display("FAIL reset_async: got gnt=%b dout=%h v=%b owner=%0d busy=%b, required all 0", gnt, dout, dout_valid, owner, busy);
    end
    req = '0;
    @(negedge clk); reset = 1'b0;
  endtask
  task automatic test_single();
    din = 16'h0A00; req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt=%b owner=%0d busy=%b, required 0100 2 1", gnt, owner, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (dout !== 4'hA || dout_valid !== 1'b1 || gnt !== '0) begin
      failures++;
      $display("FAIL single_load: dout=%h v=%b gnt=%b, required a 1 0000", dout, dout_valid, gnt);
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_hold2: v=%b required 1", dout_valid);
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== 4'hA) begin
      failures++;
      $display("FAIL single_end: v=%b busy=%b dout=%h, required 0 0 a", dout_valid, busy, dout);
    end
  endtask
  task automatic test_fairness();
    int exp_o[5] = '{0, 1, 2, 3, 0};
    int n = 0, cyc = 0, last = -1;
    logic pv = 1'b0;
    pulse_reset();
    din = {4'd4, 4'd3, 4'd2, 4'd1}; req = 4'hF;
    while (n < 5 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (dout_valid && !pv) begin
        checks++;
        if (dout !== 4'(exp_o[n] + 1) || owner !== 2'(exp_o[n])) begin
          failures++;
          $display("FAIL fair_order[%0d]: dout=%0d owner=%0d, required %0d %0d", n, dout, owner, exp_o[n] + 1, exp_o[n]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 4) begin
            failures++;
            $display("FAIL fair_spacing[%0d]: %0d cycles, required 4", n, cyc - last);
          end
        end
        last = cyc; n++;
      end
      pv = dout_valid;
    end
    if (n < 5) begin
      checks++; failures++;
      $display("FAIL fair_timeout: %0d transfers seen, required 5", n);
    end
  endtask
  task automatic test_wrap();
    req = 4'b1000;
    wait_gnt();
    checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      failures++;
      $display("FAIL wrap_g3: gnt=%b owner=%0d, required 1000 3", gnt, owner);
    end
    req = 4'b1001;
    @(negedge clk);
    wait_gnt();
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      failures++;
      $display("FAIL wrap_g0: gnt=%b owner=%0d, required 0001 0", gnt, owner);
    end
  endtask
  task automatic test_drop_in_load();
    int n = 0;
    req = '0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    din = 16'h0050; req = 4'b0010;
    wait_gnt();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL drop_gnt: gnt=%b required 0010", gnt);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (dout !== 4'h5 || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL drop_load: dout=%h v=%b, required 5 1", dout, dout_valid);
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL drop_hold2: v=%b required 1", dout_valid);
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_end: v=%b busy=%b, required 0 0", dout_valid, busy);
    end
  endtask
  task automatic test_reset_in_hold();
    int n = 0;
    din = 16'h7777; req = 4'b0100;
    while (!dout_valid && n < 20) begin @(negedge clk); n++; end
    req = 4'hF;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt, dout, dout_valid, owner, busy} !== '0) begin
      failures++;
      $display("FAIL reset_hold: gnt=%b dout=%h v=%b owner=%0d busy=%b, required all 0", gnt, dout, dout_valid, owner, busy);
    end
    @(negedge clk); reset = 1'b0;
    wait_gnt();
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      failures++;
      $display("FAIL reset_hold_regrant: gnt=%b owner=%0d, required 0001 0", gnt, owner);
    end
  endtask
  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== m_gnt || owner !== m_owner || dout !== m_dout || dout_valid !== m_valid || busy !== (m_t != 0)) begin
        failures++;
        $display("FAIL rand_cycle%0d: gnt=%b owner=%0d dout=%h v=%b busy=%b, required %b %0d %h %b %b",
                 c, gnt, owner, dout, dout_valid, busy, m_gnt, m_owner, m_dout, m_valid, m_t != 0);
      end
      checks++;
      if (!$onehot0(gnt)) begin
        failures++;
        $display("FAIL rand_onehot%0d: gnt=%b required zero or one-hot", c, gnt);
      end
      req = ($urandom_range(0, 9) < 3) ? '0 : N'($urandom_range(1, 15));
      din = (N*DW)'($urandom);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_drop_in_load();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
